// File: rtl/lbist_pkg.sv
// Shared types and constants for the logic-BIST sequencer.
package lbist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        FLUSH   = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } lbist_state_e;

    typedef struct packed {
        logic lfsr_load;
        logic lfsr_en;
        logic misr_clr;
        logic misr_en;
        logic test_mode;
        logic busy;
        logic done;
    } lbist_ctrl_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // MISR polynomial: MSB is fed back into bits 0, 1, 5 and 6.
    localparam logic [7:0] MISR_TAPS = 8'b0110_0011;

endpackage

// File: rtl/lbist_pat_counter.sv
// Pattern counter: latches the run length, counts applied patterns, flags the last one.
module lbist_pat_counter
    import lbist_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit_in,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             empty
);

    logic [CNT_W-1:0] limit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            limit <= '0;
        end else if (load) begin
            cnt   <= '0;
            limit <= limit_in;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Only consulted while running, where limit is known to be non-zero.
    assign last  = (cnt == limit - 1'b1);
    assign empty = (limit == '0);

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST sequencer: LFSR seeding, pattern run, CUT flush, signature compare.
// Optional abort input enabled by defining LBIST_ABORT_EN.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int CUT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic [WIDTH-1:0] misr_sig,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_en,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pat_cnt
`ifdef LBIST_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [3:0] FLUSH_LAST = 4'(CUT_LAT > 0 ? CUT_LAT - 1 : 0);

    lbist_state_e     state, next_state;
    lbist_ctrl_t      ctrl_next, ctrl_q;
    logic [3:0]       flush_cnt;
    logic [WIDTH-1:0] golden_q;
    logic             accept, cnt_last, cnt_empty, abort_req, in_busy;

`ifdef LBIST_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept  = start && (state == IDLE || state == DONE);
    assign in_busy = state inside {INIT, RUN, FLUSH, COMPARE};

    lbist_pat_counter #(.CNT_W(CNT_W)) u_pat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .inc      (state == RUN),
        .limit_in (num_patterns),
        .cnt      (pat_cnt),
        .last     (cnt_last),
        .empty    (cnt_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ctrl_q    <= '0;
            flush_cnt <= '0;
            lfsr_seed <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= next_state;
            ctrl_q    <= ctrl_next;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 4'd1 : 4'd0;
            if (accept) begin
                lfsr_seed <= seed;
                pass      <= 1'b0;
            end else if (state == COMPARE && !abort_req) begin
                pass <= (misr_sig == golden_q);
            end
        end
    end

    // Golden value is pure data; it is always rewritten before it is compared.
    always_ff @(posedge clk) begin
        if (accept) golden_q <= golden_sig;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        next_state = state;
        ctrl_next  = '0;
        case (state)
            IDLE, DONE: if (start) next_state = INIT;
            INIT:       next_state = cnt_empty ? COMPARE : RUN;
            RUN:        if (cnt_last) next_state = (CUT_LAT == 0) ? COMPARE : FLUSH;
            FLUSH:      if (flush_cnt == FLUSH_LAST) next_state = COMPARE;
            COMPARE:    next_state = DONE;
            default:    next_state = IDLE;
        endcase
        if (abort_req && in_busy) next_state = DONE;

        ctrl_next.lfsr_load = (next_state == INIT);
        ctrl_next.misr_clr  = (next_state == INIT);
        ctrl_next.lfsr_en   = (next_state == RUN);
        ctrl_next.misr_en   = (next_state == RUN) || (next_state == FLUSH);
        ctrl_next.test_mode = next_state inside {INIT, RUN, FLUSH};
        ctrl_next.busy      = next_state inside {INIT, RUN, FLUSH, COMPARE};
        ctrl_next.done      = (next_state == DONE);
    end

    assign lfsr_load = ctrl_q.lfsr_load;
    assign lfsr_en   = ctrl_q.lfsr_en;
    assign misr_clr  = ctrl_q.misr_clr;
    assign misr_en   = ctrl_q.misr_en;
    assign test_mode = ctrl_q.test_mode;
    assign busy      = ctrl_q.busy;
    assign done      = ctrl_q.done;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl with a behavioural LFSR/CUT/MISR loop closing misr_sig.
module tb_lbist_ctrl;
    import lbist_pkg::*;

    localparam int CUT_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_patterns = '0;
    logic [7:0]  seed = '0;
    logic [7:0]  golden_sig = '0;
    logic [7:0]  misr_sig;
    logic        lfsr_load, lfsr_en, misr_clr, misr_en, test_mode, busy, done, pass;
    logic [7:0]  lfsr_seed;
    logic [15:0] pat_cnt;
`ifdef LBIST_ABORT_EN
    logic        abort = 1'b0;
`endif

    lbist_ctrl #(.WIDTH(8), .CNT_W(16), .CUT_LAT(CUT_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .seed         (seed),
        .golden_sig   (golden_sig),
        .misr_sig     (misr_sig),
        .lfsr_load    (lfsr_load),
        .lfsr_seed    (lfsr_seed),
        .lfsr_en      (lfsr_en),
        .misr_clr     (misr_clr),
        .misr_en      (misr_en),
        .test_mode    (test_mode),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .pat_cnt      (pat_cnt)
`ifdef LBIST_ABORT_EN
        ,
        .abort        (abort)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [7:0] d);
        return {m[6:0], 1'b0} ^ (m[7] ? MISR_TAPS : 8'h00) ^ d;
    endfunction

    // Expected signature: n patterns plus CUT_LAT flush captures, no captures when n == 0.
    function automatic logic [7:0] ref_sig(input int n, input logic [7:0] sd);
        logic [7:0] l, m;
        l = sd;
        m = 8'h00;
        if (n == 0) return 8'h00;
        for (int i = 0; i < n + CUT_LAT; i++) begin
            m = misr_step(m, l ^ 8'h5A);
            if (i < n) l = lfsr_next(l);
        end
        return m;
    endfunction

    // Datapath loop driven by the DUT controls; CUT is combinational l ^ 8'h5A.
    logic [7:0] lfsr_q = 8'h00;
    logic [7:0] misr_q = 8'h00;
    assign misr_sig = misr_q;

    always @(posedge clk) begin
        if (lfsr_load)    lfsr_q <= lfsr_seed;
        else if (lfsr_en) lfsr_q <= lfsr_next(lfsr_q);
        if (misr_clr)     misr_q <= 8'h00;
        else if (misr_en) misr_q <= misr_step(misr_q, test_mode ? (lfsr_q ^ 8'h5A) : 8'h00);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {lfsr_load, lfsr_en, misr_clr, misr_en, test_mode, busy, done, pass}, 0);
        check({name, "_seed"}, lfsr_seed, 0);
        check({name, "_cnt"}, pat_cnt, 0);
    endtask

    typedef struct {
        int         n;
        logic [7:0] sd;
        logic [7:0] flip;
        int         poke;
        logic       exp_pass;
        int         exp_lat;
        int         exp_len;
        int         exp_men;
        int         exp_tm;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int lat, c_load, c_clr, c_len, c_men, c_tm, run_idx;
        lat = 0; c_load = 0; c_clr = 0; c_len = 0; c_men = 0; c_tm = 0; run_idx = 0;
        @(negedge clk);
        num_patterns = 16'(v.n);
        seed         = v.sd;
        golden_sig   = ref_sig(v.n, v.sd) ^ v.flip;
        start        = 1'b1;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            start = (v.poke != 0 && lat == v.poke);
            if (lat == 1) begin
                check("done_low_after_start", done, 0);
                check("busy_after_start", busy, 1);
                check("seed_registered", lfsr_seed, v.sd);
            end
            c_load += int'(lfsr_load);
            c_clr  += int'(misr_clr);
            c_len  += int'(lfsr_en);
            c_men  += int'(misr_en);
            c_tm   += int'(test_mode);
            if (lfsr_en) begin
                check("pat_cnt_in_run", pat_cnt, run_idx);
                run_idx++;
            end
            if (done) break;
        end
        start = 1'b0;
        check("latency", lat, v.exp_lat);
        check("lfsr_load_cycles", c_load, 1);
        check("misr_clr_cycles", c_clr, 1);
        check("lfsr_en_cycles", c_len, v.exp_len);
        check("misr_en_cycles", c_men, v.exp_men);
        check("test_mode_cycles", c_tm, v.exp_tm);
        check("pass", pass, v.exp_pass);
        check("final_pat_cnt", pat_cnt, v.n);
        check("busy_at_done", busy, 0);
    endtask

    initial begin
        //          n   seed   flip   poke pass lat len men tm
        vecs[0] = '{4,  8'hA5, 8'h00, 0,   1'b1, 8, 4,  5,  6};
        vecs[1] = '{4,  8'hA5, 8'h10, 0,   1'b0, 8, 4,  5,  6};
        vecs[2] = '{0,  8'h3C, 8'h00, 0,   1'b1, 3, 0,  0,  1};
        vecs[3] = '{0,  8'h3C, 8'h01, 0,   1'b0, 3, 0,  0,  1};
        vecs[4] = '{1,  8'h01, 8'h00, 0,   1'b1, 5, 1,  2,  3};
        vecs[5] = '{7,  8'hFF, 8'h80, 0,   1'b0, 11, 7, 8,  9};
        vecs[6] = '{6,  8'h5A, 8'h00, 4,   1'b1, 10, 6, 7,  8};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        num_patterns = 16'd10;
        seed         = 8'h77;
        golden_sig   = 8'h00;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 50 && !(lfsr_en && pat_cnt == 16'd5); k++) begin
            @(posedge clk);
            #1;
        end
        check("reached_pat_cnt_5", pat_cnt, 5);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

`ifdef LBIST_ABORT_EN
        @(negedge clk);
        num_patterns = 16'd10;
        seed         = 8'h11;
        golden_sig   = ref_sig(10, 8'h11);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 50 && !(lfsr_en && pat_cnt == 16'd2); k++) begin
            @(posedge clk);
            #1;
        end
        check("abort_reached_cnt_2", pat_cnt, 2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_done", done, 1);
        check("abort_pass", pass, 0);
        check("abort_pat_cnt", pat_cnt, 3);
        check("abort_enables", {lfsr_load, lfsr_en, misr_clr, misr_en, test_mode, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_cnt_frozen", pat_cnt, 3);
        check("abort_done_held", done, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
